// File: rtl/binary_arith_pkg.sv
// ---------------------------------------------------------------------------
// binary_arith_pkg
// Shared definitions for the sequential binary arithmetic blocks.
//   DIV_WIDTH_DEFAULT : default operand width of the divider
//   div_state_e       : divider control states (IDLE, CALC, DONE)
// ---------------------------------------------------------------------------
package binary_arith_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// ---------------------------------------------------------------------------
// div_trial_sub
// Combinational (WIDTH+1)-bit trial subtraction used by the restoring divider.
// It computes a - b as a + ~b + 1.
//   a      : minuend, WIDTH+1 bits (shifted partial remainder)
//   b      : subtrahend, WIDTH+1 bits (zero-extended divisor)
//   diff   : a - b, modulo 2^(WIDTH+1)
//   borrow : 1 when a < b (no carry out of the two's complement add)
// ---------------------------------------------------------------------------
module div_trial_sub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    logic [WIDTH+1:0] sum;

    // An extra top bit catches the carry out; carry set means a >= b,
    // so the borrow is simply its inverse.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{(WIDTH + 1){1'b0}}, 1'b1};
        diff   = sum[WIDTH:0];
        borrow = ~sum[WIDTH+1];
    end

endmodule

// File: rtl/binary_div_seq.sv
// ---------------------------------------------------------------------------
// binary_div_seq
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst     : clock and synchronous active-high reset
//   start        : request a division (only looked at while idle)
//   dividend     : unsigned dividend, captured on the accepted start
//   divisor      : unsigned divisor, captured on the accepted start
//   busy         : high while a division is running (CALC and DONE)
//   done         : one-cycle pulse when quotient/remainder are fresh
//   quotient     : unsigned quotient (all ones on divide by zero)
//   remainder    : unsigned remainder (dividend on divide by zero)
//   div_by_zero  : last completed division had a zero divisor
// ---------------------------------------------------------------------------
module binary_div_seq
    import binary_arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;

    // dq_q starts as the dividend and doubles as the quotient shift
    // register: its MSB feeds the partial remainder while quotient bits
    // enter at the LSB, so after WIDTH steps it holds the quotient.
    assign shifted = (rem_q << 1) | {{WIDTH{1'b0}}, dq_q[WIDTH-1]};

    div_trial_sub #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .a      (shifted),
        .b      ({1'b0, dvs_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // Next-state and datapath logic. The visible results are only
    // rewritten on the step that enters DONE, so they hold steady
    // through CALC and between divisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dq_d        = dq_q;
        dvs_d       = dvs_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (divisor != '0) begin
                        state_d = CALC;
                        dq_d    = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                    end else begin
                        // Divide by zero skips CALC and reports at once.
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end
                end
            end

            CALC: begin
                rem_d = trial_borrow ? shifted : trial_diff;
                dq_d  = {dq_q[WIDTH-2:0], ~trial_borrow};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    quotient_d  = dq_d;
                    remainder_d = rem_d[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset overrides start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            dvs_q       <= dvs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_binary_div_seq.sv
// ---------------------------------------------------------------------------
// tb_binary_div_seq
// Self-checking bench for binary_div_seq at WIDTH=4. Expected results come
// from plain integer division in the bench; timing expectations come from
// the latency rules (done one cycle after a zero-divisor start, WIDTH+1
// cycles after a nonzero one).
// ---------------------------------------------------------------------------
module tb_binary_div_seq;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    binary_div_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison point: counts it and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference arithmetic, including the divide-by-zero convention.
    function automatic logic [WIDTH-1:0] modelQuot(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        return (b == 0) ? {WIDTH{1'b1}} : WIDTH'(int'(a) / int'(b));
    endfunction

    function automatic logic [WIDTH-1:0] modelRem(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return (b == 0) ? a : WIDTH'(int'(a) % int'(b));
    endfunction

    // Launch one division and follow it until done or a cycle budget runs
    // out. Cycle 1 is the first sample after the accept edge. Optionally
    // pokes start with other operands at pokeAt, or raises rst at rstAt.
    // doneCycle is -1 when no done was seen within the budget.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int pokeAt, input logic [WIDTH-1:0] pokeA,
                                 input logic [WIDTH-1:0] pokeB, input int rstAt,
                                 output int doneCycle, output logic held);
        logic [WIDTH-1:0] q0, r0;
        logic             z0;
        q0 = quotient;
        r0 = remainder;
        z0 = div_by_zero;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        checkOutput($sformatf("busy_after_accept %0h/%0h", a, b), busy, 1'b1);
        doneCycle = -1;
        held      = 1'b1;
        for (int cyc = 1; cyc <= 3 * WIDTH + 4; cyc++) begin
            if (done) begin
                doneCycle = cyc;
                break;
            end
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0)
                held = 1'b0;
            start = (cyc == pokeAt);
            if (cyc == pokeAt) begin
                dividend = pokeA;
                divisor  = pokeB;
            end
            rst = (cyc == rstAt);
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    // Full division with result, latency, hold and pulse-width checks.
    task automatic runAndCheck(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input int pokeAt, input logic [WIDTH-1:0] pokeA,
                               input logic [WIDTH-1:0] pokeB);
        int   dc;
        logic held;
        string op;
        op = $sformatf("%0h/%0h", a, b);
        applyStimulus(a, b, pokeAt, pokeA, pokeB, -1, dc, held);
        checkOutput({"latency ", op}, dc, (b == 0) ? 1 : WIDTH + 1);
        checkOutput({"quotient ", op}, quotient, modelQuot(a, b));
        checkOutput({"remainder ", op}, remainder, modelRem(a, b));
        checkOutput({"div_by_zero ", op}, div_by_zero, (b == 0));
        checkOutput({"hold_during_calc ", op}, held, 1'b1);
        tick();
        checkOutput({"done_one_cycle ", op}, done, 1'b0);
        checkOutput({"busy_back_idle ", op}, busy, 1'b0);
    endtask

    initial begin
        int   dc;
        logic held;

        $display("[TB] binary_div_seq bench, WIDTH=%0d", WIDTH);
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_quotient", quotient, 4'h0);
        checkOutput("reset_remainder", remainder, 4'h0);
        checkOutput("reset_div_by_zero", div_by_zero, 1'b0);

        // Reset and start together: reset must win.
        start    = 1'b1;
        dividend = 4'hD;
        divisor  = 4'h3;
        tick();
        checkOutput("rst_beats_start_busy", busy, 1'b0);
        checkOutput("rst_beats_start_done", done, 1'b0);
        rst   = 1'b0;
        start = 1'b0;

        // Start on the very first edge after reset release.
        $display("[TB] directed divisions");
        runAndCheck(4'b1101, 4'b0100, -1, '0, '0);
        runAndCheck(4'b0111, 4'b0000, -1, '0, '0);
        runAndCheck(4'b1111, 4'b0001, -1, '0, '0);
        runAndCheck(4'b0011, 4'b0101, -1, '0, '0);
        runAndCheck(4'b1111, 4'b1111, -1, '0, '0);
        checkOutput("allones_quotient_const", quotient, 4'b0001);

        // Start pulsed mid-division is ignored; a fresh start then works.
        runAndCheck(4'b1101, 4'b0100, 2, 4'b1000, 4'b0010);
        checkOutput("ignored_start_quotient", quotient, 4'b0011);
        checkOutput("ignored_start_remainder", remainder, 4'b0001);
        runAndCheck(4'b1000, 4'b0010, -1, '0, '0);

        // Reset mid-CALC aborts with no done and clears the outputs.
        $display("[TB] reset abort");
        applyStimulus(4'b1001, 4'b0010, -1, '0, '0, 3, dc, held);
        checkOutput("abort_no_done", dc, -1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_quotient", quotient, 4'h0);
        checkOutput("abort_remainder", remainder, 4'h0);
        checkOutput("abort_div_by_zero", div_by_zero, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        runAndCheck(4'b1001, 4'b0010, -1, '0, '0);
        checkOutput("after_abort_quotient_const", quotient, 4'b0100);

        // Exhaustive sweep of every operand pair.
        $display("[TB] exhaustive sweep");
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                runAndCheck(WIDTH'(a), WIDTH'(b), -1, '0, '0);
            end
        end

        // Random operands with a random stray start during the division.
        $display("[TB] random divisions with stray starts");
        for (int n = 0; n < 40; n++) begin
            runAndCheck(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(1, WIDTH),
                        WIDTH'($urandom), WIDTH'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
